// File: rtl/w_buf_wr.sv
// w_buf_wr: write-side loader for the weight buffer.
//
// Accepts WIDTH-bit words over a valid/ready stream and packs COL consecutive
// words into one row. The first word of a row lands in the top lane. One
// row-wide write is issued per row at addresses 0..DEPTH-1. After the last
// row, the loader sits in DONE until the next start.
//
// Optional feature: define W_BUF_WR_CHECKSUM_EN to add checksum_o. This output
// is the modulo-2^WIDTH sum of every word accepted since the last start.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_i       in   asynchronous active-low reset
//   start_i     in   begin a load; sampled only in IDLE or DONE
//   s_valid_i   in   stream word valid
//   s_data_i    in   stream word
//   s_ready_o   out  loader can accept a word (FILL)
//   wr_en_o     out  one-cycle row write strobe
//   wr_addr_o   out  row address, held outside WRITE
//   wr_data_o   out  packed row, held outside WRITE
//   busy_o      out  load in progress (FILL or WRITE)
//   done_o      out  all rows written; held until next start or reset
//   checksum_o  out  running word sum (only with W_BUF_WR_CHECKSUM_EN)
module w_buf_wr #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned COL        = 10,
  // Clamped to 1 so that degenerate DEPTH=1 / COL=1 builds keep legal vectors.
  parameter int unsigned ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned CNT_WIDTH  = (COL > 1) ? $clog2(COL) : 1
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   s_valid_i,
  input  logic [WIDTH-1:0]       s_data_i,
  output logic                   s_ready_o,
  output logic                   wr_en_o,
  output logic [ADDR_WIDTH-1:0]  wr_addr_o,
  output logic [WIDTH*COL-1:0]   wr_data_o,
  output logic                   busy_o,
`ifdef W_BUF_WR_CHECKSUM_EN
  output logic [WIDTH-1:0]       checksum_o,
`endif
  output logic                   done_o
);

  localparam logic [CNT_WIDTH-1:0]  LastCnt  = CNT_WIDTH'(COL - 1);
  localparam logic [CNT_WIDTH-1:0]  CntOne   = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StFill, StWrite, StDone} state_e;

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0]   row_addr_q, row_addr_d;
  logic [WIDTH*COL-1:0]    row_q, row_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [WIDTH*COL-1:0]    wr_data_q, wr_data_d;
  logic                    hs;
  logic                    load_start;
  int unsigned             lane;

  // Ready is pure state decode, so the handshake only needs valid plus state.
  assign hs         = s_valid_i && (state_q == StFill);
  assign load_start = start_i && ((state_q == StIdle) || (state_q == StDone));
  assign lane       = COL - 1 - 32'(word_cnt_q);

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    row_addr_d = row_addr_q;
    row_d      = row_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d    = StFill;
          row_addr_d = '0;
          word_cnt_d = '0;
        end
      end
      StFill: begin
        if (hs) begin
          row_d[lane*WIDTH +: WIDTH] = s_data_i;
          if (word_cnt_q == LastCnt) begin
            word_cnt_d = '0;
            state_d    = StWrite;
            // Capture the completed row so the write port holds it afterwards.
            wr_data_d  = row_d;
            wr_addr_d  = row_addr_q;
          end else begin
            word_cnt_d = word_cnt_q + CntOne;
          end
        end
      end
      StWrite: begin
        row_d = '0;
        if (row_addr_q == LastAddr) begin
          state_d = StDone;
        end else begin
          row_addr_d = row_addr_q + AddrOne;
          state_d    = StFill;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      row_addr_q <= '0;
      row_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      row_addr_q <= row_addr_d;
      row_q      <= row_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

`ifdef W_BUF_WR_CHECKSUM_EN
  logic [WIDTH-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (load_start) begin
      csum_d = '0;
    end else if (hs) begin
      csum_d = csum_q + s_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum_o = csum_q;
`else
  logic unused_load_start;
  assign unused_load_start = load_start;
`endif

  assign s_ready_o = (state_q == StFill);
  assign wr_en_o   = (state_q == StWrite);
  assign busy_o    = (state_q == StFill) || (state_q == StWrite);
  assign done_o    = (state_q == StDone);
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_w_buf_wr.sv
// Bench for w_buf_wr with WIDTH=8, COL=4, DEPTH=2. Expected row writes are
// queued when words are driven and compared when wr_en_o pulses.
module tb_w_buf_wr;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned COL   = 4;

  logic             clk;
  logic             rst_i;
  logic             start_i;
  logic             s_valid_i;
  logic [WIDTH-1:0] s_data_i;
  logic             s_ready_o;
  logic             wr_en_o;
  logic [0:0]       wr_addr_o;
  logic [31:0]      wr_data_o;
  logic             busy_o;
  logic             done_o;
`ifdef W_BUF_WR_CHECKSUM_EN
  logic [WIDTH-1:0] checksum_o;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [0:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  logic [7:0] words [8];

  w_buf_wr #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .COL   (COL)
  ) dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .s_valid_i  (s_valid_i),
    .s_data_i   (s_data_i),
    .s_ready_o  (s_ready_o),
    .wr_en_o    (wr_en_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .busy_o     (busy_o),
`ifdef W_BUF_WR_CHECKSUM_EN
    .checksum_o (checksum_o),
`endif
    .done_o     (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wr_en_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%h, required no write",
                 wr_addr_o, wr_data_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wr_addr_o !== e.addr || wr_data_o !== e.data) begin
          errors++;
          $display("FAIL row_write: got addr=%0h data=%h, required addr=%0h data=%h",
                   wr_addr_o, wr_data_o, e.addr, e.data);
        end
      end
    end
  end

  // Queue the expected rows for words[first..first+nrows*COL-1] at addr base.
  task automatic push_rows(input int first, input int nrows, input int base);
    for (int r = 0; r < nrows; r++) begin
      wr_t e;
      e.data = '0;
      for (int c = 0; c < int'(COL); c++) e.data = (e.data << 8) | 32'(words[first + r*COL + c]);
      e.addr = 1'(base + r);
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [7:0] d, output int waits);
    logic hs;
    waits = 0;
    s_valid_i = 1'b1;
    s_data_i  = d;
    do begin
      hs = s_ready_o;
      @(negedge clk);
      waits++;
    end while (!hs && waits < 50);
    s_valid_i = 1'b0;
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no handshake in %0d cycles, required one", waits);
    end
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: got done_o=%b, required 1", done_o);
    end
  endtask

  task automatic test_reset();
    int w;
    rst_i = 1'b0; start_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0;
    #12;
    checks++;
    if ({s_ready_o, wr_en_o, busy_o, done_o, wr_addr_o} !== 5'b0 || wr_data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b wr=%b busy=%b done=%b addr=%0h data=%h, required all 0",
               s_ready_o, wr_en_o, busy_o, done_o, wr_addr_o, wr_data_o);
    end
    @(negedge clk); rst_i = 1'b1;
    @(negedge clk);
    do_start();
    send(8'hA1, w);
    send(8'hA2, w);
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if ({s_ready_o, wr_en_o, busy_o, done_o, wr_addr_o} !== 5'b0 || wr_data_o !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b wr=%b busy=%b done=%b addr=%0h data=%h, required all 0",
               s_ready_o, wr_en_o, busy_o, done_o, wr_addr_o, wr_data_o);
    end
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (s_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got rdy=%b busy=%b, required 0 0", s_ready_o, busy_o);
    end
  endtask

  task automatic test_full_load();
    int w;
    for (int i = 0; i < 8; i++) words[i] = 8'(i + 1);
    push_rows(0, 2, 0);
    do_start();
    for (int i = 0; i < 8; i++) send(words[i], w);
    wait_done();
    checks++;
    if (busy_o !== 1'b0 || s_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL done_outputs: got busy=%b rdy=%b, required 0 0", busy_o, s_ready_o);
    end
  endtask

  task automatic test_backpressure();
    int w;
    for (int i = 0; i < 8; i++) words[i] = 8'(8'h31 + i);
    push_rows(0, 2, 0);
    do_start();
    for (int i = 0; i < 4; i++) send(words[i], w);
    checks++;
    if (s_ready_o !== 1'b0 || wr_en_o !== 1'b1) begin
      errors++;
      $display("FAIL write_bubble: got rdy=%b wr_en=%b, required 0 1", s_ready_o, wr_en_o);
    end
    send(words[4], w);
    checks++;
    if (w !== 2) begin
      errors++;
      $display("FAIL fifth_word_latency: got %0d cycles, required 2", w);
    end
    for (int i = 5; i < 8; i++) send(words[i], w);
    wait_done();
  endtask

  task automatic test_stalls();
    int w;
    for (int i = 0; i < 8; i++) words[i] = 8'(i + 1);
    push_rows(0, 2, 0);
    do_start();
    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (i % 4 != 0) begin
          checks++;
          if (s_ready_o !== 1'b1 || wr_en_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: got rdy=%b wr_en=%b, required 1 0", s_ready_o, wr_en_o);
          end
        end
      end
      send(words[i], w);
    end
    wait_done();
  endtask

  task automatic test_restart();
    int w;
    for (int i = 0; i < 8; i++) words[i] = 8'(8'h11 + i);
    push_rows(0, 2, 0);
    do_start();
    send(words[0], w);
    send(words[1], w);
    do_start();
    checks++;
    if (busy_o !== 1'b1 || s_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL start_in_fill: got busy=%b rdy=%b, required 1 1", busy_o, s_ready_o);
    end
    for (int i = 2; i < 8; i++) send(words[i], w);
    wait_done();
    for (int i = 0; i < 8; i++) words[i] = 8'(8'h21 + i);
    push_rows(0, 2, 0);
    do_start();
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL restart_from_done: got done=%b busy=%b, required 0 1", done_o, busy_o);
    end
    for (int i = 0; i < 8; i++) send(words[i], w);
    wait_done();
  endtask

`ifdef W_BUF_WR_CHECKSUM_EN
  task automatic test_checksum();
    int w;
    words = '{8'hFF, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    push_rows(0, 2, 0);
    do_start();
    for (int i = 0; i < 8; i++) send(words[i], w);
    wait_done();
    repeat (2) @(negedge clk);
    checks++;
    if (checksum_o !== 8'h02) begin
      errors++;
      $display("FAIL checksum: got %h, required 02", checksum_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_load();
    test_backpressure();
    test_stalls();
    test_restart();
`ifdef W_BUF_WR_CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: got %0d rows unwritten, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
